// File: rtl/hs_mem_tdpram_be.sv
// rtl/hs_mem_tdpram_be.sv - true dual-port byte-enable RAM with post-reset clear
// Two independent RW ports on one clock; port A wins overlapping lanes on a same-address write/write.
module hs_mem_tdpram_be #(
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_BYTES = 4,
  parameter int DATA_DEPTH = 256,
  parameter bit EN_OUTPUT_REG = 1'b0,
  parameter bit EN_WRITE_FIRST = 1'b0,
  parameter bit EN_INIT_CLEAR = 1'b1,
  parameter logic [BYTE_WIDTH*NUM_BYTES-1:0] INIT_VALUE = '0,
  localparam int W = BYTE_WIDTH * NUM_BYTES,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  output logic                  collision,
  input  logic                  pa_req,
  input  logic                  pa_wen,
  input  logic [NUM_BYTES-1:0]  pa_be,
  input  logic [ADDR_WIDTH-1:0] pa_addr,
  input  logic [W-1:0]          pa_wdata,
  output logic [W-1:0]          pa_rdata,
  output logic                  pa_rvalid,
  input  logic                  pb_req,
  input  logic                  pb_wen,
  input  logic [NUM_BYTES-1:0]  pb_be,
  input  logic [ADDR_WIDTH-1:0] pb_addr,
  input  logic [W-1:0]          pb_wdata,
  output logic [W-1:0]          pb_rdata,
  output logic                  pb_rvalid
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [W-1:0] r_mem [DATA_DEPTH];

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_init_done;
  logic                  r_collision;
  logic                  r_a_rv1;
  logic                  r_b_rv1;
  logic [W-1:0]          r_a_rd1;
  logic [W-1:0]          r_b_rd1;

  logic         w_run;
  logic         w_clr_we;
  logic         w_a_in;
  logic         w_b_in;
  logic         w_a_we;
  logic         w_b_we;
  logic         w_a_rd;
  logic         w_b_rd;
  logic         w_same;
  logic [W-1:0] w_a_old;
  logic [W-1:0] w_b_old;
  logic [W-1:0] w_a_rdata;
  logic [W-1:0] w_b_rdata;

  assign w_run    = (r_state == S_RUN);
  assign w_clr_we = (r_state == S_INIT) && EN_INIT_CLEAR;
  assign w_a_in   = ({1'b0, pa_addr} < DEPTH_EXT);
  assign w_b_in   = ({1'b0, pb_addr} < DEPTH_EXT);
  assign w_a_we   = w_run && pa_req && pa_wen && w_a_in;
  assign w_b_we   = w_run && pb_req && pb_wen && w_b_in;
  assign w_a_rd   = w_run && pa_req && !pa_wen;
  assign w_b_rd   = w_run && pb_req && !pb_wen;
  assign w_same   = (pa_addr == pb_addr);
  assign w_a_old  = w_a_in ? r_mem[pa_addr] : '0;
  assign w_b_old  = w_b_in ? r_mem[pb_addr] : '0;

  // Write-first bypass: overlay the opposite port's enabled lanes onto the stored word.
  always_comb begin
    w_a_rdata = w_a_old;
    w_b_rdata = w_b_old;
    if (EN_WRITE_FIRST && w_same) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (w_b_we && pb_be[i]) w_a_rdata[i*BYTE_WIDTH +: BYTE_WIDTH] = pb_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (w_a_we && pa_be[i]) w_b_rdata[i*BYTE_WIDTH +: BYTE_WIDTH] = pa_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (!EN_INIT_CLEAR || (r_cnt == LAST_ADDR)) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_collision <= 1'b0;
      r_a_rv1     <= 1'b0;
      r_b_rv1     <= 1'b0;
      r_a_rd1     <= '0;
      r_b_rd1     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == S_RUN);
      if (w_clr_we) r_cnt <= r_cnt + 1'b1;
      r_collision <= w_a_we && w_b_we && w_same && |(pa_be & pb_be);
      r_a_rv1     <= w_a_rd;
      r_b_rv1     <= w_b_rd;
      if (w_a_rd) r_a_rd1 <= w_a_rdata;
      if (w_b_rd) r_b_rd1 <= w_b_rdata;
    end
  end

  // Port A is written after port B so it takes any lane both ports enable.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= INIT_VALUE;
    end else begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (w_b_we && pb_be[i]) r_mem[pb_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= pb_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (w_a_we && pa_be[i]) r_mem[pa_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= pa_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  if (EN_OUTPUT_REG) begin : g_oreg
    logic         r_a_rv2;
    logic         r_b_rv2;
    logic [W-1:0] r_a_rd2;
    logic [W-1:0] r_b_rd2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a_rv2 <= 1'b0;
        r_b_rv2 <= 1'b0;
        r_a_rd2 <= '0;
        r_b_rd2 <= '0;
      end else begin
        r_a_rv2 <= r_a_rv1;
        r_b_rv2 <= r_b_rv1;
        if (r_a_rv1) r_a_rd2 <= r_a_rd1;
        if (r_b_rv1) r_b_rd2 <= r_b_rd1;
      end
    end

    assign pa_rvalid = r_a_rv2;
    assign pb_rvalid = r_b_rv2;
    assign pa_rdata  = r_a_rd2;
    assign pb_rdata  = r_b_rd2;
  end else begin : g_noreg
    assign pa_rvalid = r_a_rv1;
    assign pb_rvalid = r_b_rv1;
    assign pa_rdata  = r_a_rd1;
    assign pb_rdata  = r_b_rd1;
  end

  assign init_done = r_init_done;
  assign collision = r_collision;

endmodule
